// File: rtl/sd_pkg.sv
// Shared SD command-path definitions: frame geometry, fixed header bits,
// CRC7 polynomial and the transmit FSM state encoding.
package sd_pkg;

    localparam int SD_CMD_FRAME_BITS = 48;
    localparam int SD_CMD_HDR_BITS   = 40;
    localparam int SD_CRC7_BITS      = 7;

    localparam logic SD_START_BIT = 1'b0;
    localparam logic SD_TX_BIT    = 1'b1;

    // x^7 + x^3 + 1, x^7 term implied by the shift
    localparam logic [SD_CRC7_BITS-1:0] SD_CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CRC,
        ST_END,
        ST_GAP
    } sd_cmd_state_e;

endpackage

// File: rtl/sd_cmd_tx_crc7.sv
// Serial CRC7 generator with synchronous clear and unload shift-out.
// onext_msb is the MSB the register will hold after this edge.
module crc7
    import sd_pkg::*;
(
    input  logic iclk,
    input  logic iclr,
    input  logic idata,
    input  logic iunload,
    output logic onext_msb
);

    logic [SD_CRC7_BITS-1:0] crc_q;
    logic [SD_CRC7_BITS-1:0] crc_d;
    logic                    fb;

    always_comb begin
        fb    = idata ^ crc_q[SD_CRC7_BITS-1];
        crc_d = crc_q;
        if (iclr) begin
            crc_d = '0;
        end else if (iunload) begin
            crc_d = {crc_q[SD_CRC7_BITS-2:0], 1'b0};
        end else begin
            crc_d = {crc_q[SD_CRC7_BITS-2:0], 1'b0} ^ (fb ? SD_CRC7_POLY : '0);
        end
        // Lets the parent register ocmd one cycle ahead of the CRC flops
        onext_msb = crc_d[SD_CRC7_BITS-1];
    end

    always_ff @(posedge iclk) begin
        crc_q <= crc_d;
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line frame serialiser: start, tx, index, arg, CRC7, end bit.
// Optional post-frame NCC idle gap enabled by SD_CMD_TX_NCC_EN.
//
// state | meaning
// IDLE  | waiting for istart, CRC held clear
// HDR   | shifting 40 header/argument bits, CRC accumulating
// CRC   | shifting out 7 CRC bits
// END   | driving end bit
// GAP   | NCC idle clocks before the next frame (feature build only)
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int NCC_CYCLES = 8
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        istart,
    input  logic [5:0]  iindex,
    input  logic [31:0] iarg,
    output logic        obusy,
    output logic        odone,
    output logic        ocmd,
    output logic        ocmd_oe
);

`ifdef SD_CMD_TX_NCC_EN
    localparam bit NCC_EN = 1'b1;
`else
    localparam bit NCC_EN = 1'b0;
`endif

    // The IDLE cycle carrying odone counts as the last idle clock
    localparam bit       GAP_EN   = NCC_EN && (NCC_CYCLES > 1);
    localparam logic [5:0] GAP_LOAD = (NCC_CYCLES > 1) ? 6'(NCC_CYCLES - 2) : 6'd0;

    sd_cmd_state_e state_q, state_d;
    logic [SD_CMD_HDR_BITS-1:0] shreg_q, shreg_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ocmd_q, ocmd_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        crc_clr;
    logic        crc_next_bit;

    assign crc_clr = (state_q == ST_IDLE) | ~irst_n;

    crc7 u_crc7 (
        .iclk      (iclk),
        .iclr      (crc_clr),
        .idata     (shreg_q[SD_CMD_HDR_BITS-1]),
        .iunload   (state_q == ST_CRC),
        .onext_msb (crc_next_bit)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (istart) begin
                    state_d = ST_HDR;
                    shreg_d = {SD_START_BIT, SD_TX_BIT, iindex, iarg};
                    cnt_d   = 6'(SD_CMD_HDR_BITS - 1);
                end
            end
            ST_HDR: begin
                shreg_d = {shreg_q[SD_CMD_HDR_BITS-2:0], 1'b0};
                if (cnt_q == 6'd0) begin
                    state_d = ST_CRC;
                    cnt_d   = 6'(SD_CRC7_BITS - 1);
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_CRC: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_END;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_END: begin
                if (GAP_EN) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state
        case (state_d)
            ST_HDR:  ocmd_d = shreg_d[SD_CMD_HDR_BITS-1];
            ST_CRC:  ocmd_d = crc_next_bit;
            default: ocmd_d = 1'b1;
        endcase
        oe_d   = (state_d == ST_HDR) || (state_d == ST_CRC) || (state_d == ST_END);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ocmd_q  <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ocmd_q  <= ocmd_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ocmd    = ocmd_q;
    assign ocmd_oe = oe_q;
    assign obusy   = busy_q;
    assign odone   = done_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: known-CRC command frames, back-to-back
// starts, ignored mid-frame start and asynchronous abort.
module tb_sd_cmd_tx;
    import sd_pkg::*;

    logic        iclk;
    logic        irst_n;
    logic        istart;
    logic [5:0]  iindex;
    logic [31:0] iarg;
    logic        obusy;
    logic        odone;
    logic        ocmd;
    logic        ocmd_oe;

    int n_vec = 0;
    int n_err = 0;

`ifdef SD_CMD_TX_NCC_EN
    localparam int IDLE_GAP = 8;
`else
    localparam int IDLE_GAP = 1;
`endif

    localparam logic [47:0] CMD0_FRAME  = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD8_FRAME  = 48'h48_0000_01AA_87;
    localparam logic [47:0] CMD17_FRAME = 48'h51_0000_0000_55;

    sd_cmd_tx #(.NCC_CYCLES(8)) dut (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .istart  (istart),
        .iindex  (iindex),
        .iarg    (iarg),
        .obusy   (obusy),
        .odone   (odone),
        .ocmd    (ocmd),
        .ocmd_oe (ocmd_oe)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples the 48 frame bit times starting at the next falling edge
    task automatic capture(input int pulse_at, output logic [47:0] s,
                           output int oe_n, output int done_n);
        s = '0; oe_n = 0; done_n = 0;
        for (int i = 0; i < SD_CMD_FRAME_BITS; i++) begin
            @(negedge iclk);
            s = {s[46:0], ocmd};
            oe_n += int'(ocmd_oe);
            done_n += int'(odone);
            if (pulse_at >= 0) istart = (i == pulse_at);
        end
    endtask

    task automatic launch(input logic [5:0] idx, input logic [31:0] arg);
        iindex = idx;
        iarg   = arg;
        istart = 1'b1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        iindex = 6'($urandom);
        iarg   = $urandom;
    endtask

    task automatic check_done(input string tag);
        @(negedge iclk);
        chk({tag, "_odone"}, 64'(odone), 64'd1);
        chk({tag, "_oe_after"}, 64'(ocmd_oe), 64'd0);
        chk({tag, "_busy_after"}, 64'(obusy), 64'd0);
        chk({tag, "_cmd_idle"}, 64'(ocmd), 64'd1);
    endtask

    initial begin
        logic [47:0] s;
        int oe_n, done_n, bad, done_at, done_cnt;

        irst_n = 1'b0;
        istart = 1'b0;
        iindex = '0;
        iarg   = '0;
        repeat (3) @(negedge iclk);
        chk("rst_ocmd", 64'(ocmd), 64'd1);
        chk("rst_oe", 64'(ocmd_oe), 64'd0);
        chk("rst_busy", 64'(obusy), 64'd0);
        chk("rst_done", 64'(odone), 64'd0);
        irst_n = 1'b1;
        @(negedge iclk);

        // CMD0
        launch(6'd0, 32'h0000_0000);
        capture(-1, s, oe_n, done_n);
        chk("cmd0_stream", 64'(s), 64'(CMD0_FRAME));
        chk("cmd0_oe_cycles", 64'(oe_n), 64'd48);
        chk("cmd0_no_early_done", 64'(done_n), 64'd0);
        check_done("cmd0");
        @(negedge iclk);
        chk("cmd0_done_width", 64'(odone), 64'd0);

        // CMD8 with an ignored start pulse at bit 20
        launch(6'd8, 32'h0000_01AA);
        capture(20, s, oe_n, done_n);
        chk("cmd8_stream", 64'(s), 64'(CMD8_FRAME));
        chk("cmd8_oe_cycles", 64'(oe_n), 64'd48);
        check_done("cmd8");
        oe_n = 0; done_n = 0;
        repeat (60) begin
            @(negedge iclk);
            oe_n += int'(ocmd_oe);
            done_n += int'(odone) + int'(obusy);
        end
        chk("cmd8_no_second_frame", 64'(oe_n), 64'd0);
        chk("cmd8_no_second_done", 64'(done_n), 64'd0);

        // CMD17 back-to-back with istart held high
        iindex = 6'd17;
        iarg   = 32'h0000_0000;
        istart = 1'b1;
        @(posedge iclk);
        #1;
        capture(-1, s, oe_n, done_n);
        chk("cmd17a_stream", 64'(s), 64'(CMD17_FRAME));
        chk("cmd17a_oe_cycles", 64'(oe_n), 64'd48);
        bad = 0; done_at = -1; done_cnt = 0;
        for (int j = 0; j < IDLE_GAP; j++) begin
            @(negedge iclk);
            if (ocmd_oe !== 1'b0 || ocmd !== 1'b1) bad++;
            if (odone === 1'b1) begin
                done_at = j;
                done_cnt++;
            end
        end
        chk("gap_line_idle", 64'(bad), 64'd0);
        chk("gap_done_count", 64'(done_cnt), 64'd1);
        chk("gap_done_pos", 64'(done_at), 64'(IDLE_GAP - 1));
        @(posedge iclk);
        #1;
        istart = 1'b0;
        capture(-1, s, oe_n, done_n);
        chk("cmd17b_stream", 64'(s), 64'(CMD17_FRAME));
        chk("cmd17b_oe_cycles", 64'(oe_n), 64'd48);
        check_done("cmd17b");

        // Asynchronous abort at bit 30, then clean CMD0
        repeat (3) @(negedge iclk);
        launch(6'd0, 32'h0000_0000);
        s = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge iclk);
            s = {s[46:0], ocmd};
        end
        chk("abort_prefix", 64'(s[29:0]), 64'(CMD0_FRAME[47:18]));
        #2;
        irst_n = 1'b0;
        #1;
        chk("abort_ocmd", 64'(ocmd), 64'd1);
        chk("abort_oe", 64'(ocmd_oe), 64'd0);
        chk("abort_busy", 64'(obusy), 64'd0);
        repeat (3) @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        chk("post_abort_oe", 64'(ocmd_oe), 64'd0);
        launch(6'd0, 32'h0000_0000);
        capture(-1, s, oe_n, done_n);
        chk("post_abort_stream", 64'(s), 64'(CMD0_FRAME));
        check_done("post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
